pll_reset_ctrl: RTL and testbench

- Sequences the PLL (refclk in, extlock out) and the CPU reset. It drives the PLL reset, waits for lock with a timeout and retry, and qualifies lock stability.
- It releases the synchronous-deassert system reset to the core only after a stable lock. On loss of lock it re-asserts the system reset and restarts the PLL.
- It runs on the free-running pre-PLL reference clock. It sits at top level between the board reset input, the PLL instance and the core reset tree.

---
 rtl/pll_ctrl_pkg.sv | 28 ++
 rtl/pll_reset_ctrl_sync2ff.sv | 28 ++
 rtl/pll_reset_ctrl.sv | 135 +++++++++++++
 tb/tb_pll_reset_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
// Shared definitions for the PLL / core reset sequencer: controller state
// codes, retry counter width and a saturating increment helper.
package pll_ctrl_pkg;

    // Controller state codes (also exported on ctrl_state for debug LEDs)
    typedef enum logic [1:0] {
        S_PLLRST = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } ctrl_state_e;

    localparam int RETRY_W = 4;

    // Saturating increment: sticks at all-ones so a dead PLL cannot wrap the
    // retry counter back to a healthy-looking value.
    function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] val);
        logic [RETRY_W-1:0] res;
        if (val == {RETRY_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(RETRY_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync2ff.sv
// sync2ff
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops to 0
//   d   - asynchronous input
//   q   - synchronized output, two clk edges behind d
module sync2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture; first stage may go metastable, second resolves it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
// Brings up the PLL and releases the core reset only after a stable lock.
// Holds the PLL in reset, waits for lock (timing out and retrying), requires
// lock to hold for STABLE_CYC cycles, then releases sys_rst_n. Losing lock in
// RUN re-asserts the core reset and restarts the PLL. Runs on the
// free-running reference clock.
// Ports:
//   clk        - reference clock (pre-PLL)
//   reset      - asynchronous active-high board reset
//   extlock    - PLL lock, asynchronous to clk
//   pll_reset  - active-high PLL reset, high only in S_PLLRST
//   sys_rst_n  - active-low core reset, async assert / sync deassert
//   pll_ready  - high while in S_RUN
//   ctrl_state - current state code
//   retry_cnt  - saturating count of lock timeouts
//   lock_lost  - sticky flag, set when lock drops in S_RUN
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC  = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned STABLE_CYC   = 256,
    parameter int unsigned USE_LOCK     = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               extlock,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               pll_ready,
    output logic [1:0]         ctrl_state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               lock_lost
);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    ctrl_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             lock_s;

    generate
        if (USE_LOCK != 0) begin : g_lock_sync
            sync2ff u_lock_sync (
                .clk (clk),
                .rst (reset),
                .d   (extlock),
                .q   (lock_s)
            );
        end else begin : g_lock_const
            // Simulation PLL model never reports lock; treat it as locked
            logic lock_unused_s;
            assign lock_unused_s = extlock;
            assign lock_s        = 1'b1;
        end
    endgenerate

    assign ctrl_state = state_r;

    // Sequencer FSM; outputs are registered alongside the state so they change on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_PLLRST;
            cnt_r     <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ready <= 1'b0;
            retry_cnt <= '0;
            lock_lost <= 1'b0;
        end else begin
            case (state_r)
                S_PLLRST: begin
                    if (cnt_r == PLL_RST_LAST) begin
                        state_r   <= S_WAIT;
                        cnt_r     <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    // Lock takes priority over a coincident timeout
                    if (lock_s) begin
                        state_r <= S_STABLE;
                        cnt_r   <= '0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r   <= S_PLLRST;
                        cnt_r     <= '0;
                        pll_reset <= 1'b1;
                        retry_cnt <= retry_sat_inc(retry_cnt);
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_STABLE: begin
                    // A dropout restarts the timeout window without counting a retry
                    if (!lock_s) begin
                        state_r <= S_WAIT;
                        cnt_r   <= '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r   <= S_RUN;
                        sys_rst_n <= 1'b1;
                        pll_ready <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_r   <= S_PLLRST;
                        cnt_r     <= '0;
                        pll_reset <= 1'b1;
                        sys_rst_n <= 1'b0;
                        pll_ready <= 1'b0;
                        lock_lost <= 1'b1;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                default: begin
                    state_r   <= S_PLLRST;
                    cnt_r     <= '0;
                    pll_reset <= 1'b1;
                    sys_rst_n <= 1'b0;
                    pll_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl
// Self-checking bench for pll_reset_ctrl with short timing parameters.
// Each scenario queues expected (edge, signal, value) entries, then clocks
// the design and compares on the falling edge after each rising edge.
// Edge 0 is the first rising edge after reset is released.
module tb_pll_reset_ctrl;
    import pll_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       extlock = 1'b0;
    logic       pll_reset, sys_rst_n, pll_ready, lock_lost;
    logic [1:0] ctrl_state;
    logic [3:0] retry_cnt;
    logic       nl_pll_reset, nl_sys_rst_n, nl_pll_ready, nl_lock_lost;
    logic [1:0] nl_ctrl_state;
    logic [3:0] nl_retry_cnt;

    int total = 0;
    int bad   = 0;

    typedef enum int {O_PLLRST, O_SYSRST, O_READY, O_STATE, O_RETRY, O_LOST, O_NL_SYSRST} obs_e;
    typedef struct {
        int         edge_i;
        obs_e       sig;
        logic [3:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pll_reset_ctrl #(.PLL_RST_CYC(4), .LOCK_TIMEOUT(16), .STABLE_CYC(8), .USE_LOCK(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .extlock(extlock),
        .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .pll_ready(pll_ready),
        .ctrl_state(ctrl_state), .retry_cnt(retry_cnt), .lock_lost(lock_lost)
    );

    pll_reset_ctrl #(.PLL_RST_CYC(4), .LOCK_TIMEOUT(16), .STABLE_CYC(8), .USE_LOCK(0), .CNT_W(16)) u_nolock (
        .clk(clk), .reset(reset), .extlock(1'b0),
        .pll_reset(nl_pll_reset), .sys_rst_n(nl_sys_rst_n), .pll_ready(nl_pll_ready),
        .ctrl_state(nl_ctrl_state), .retry_cnt(nl_retry_cnt), .lock_lost(nl_lock_lost)
    );

    function automatic logic [3:0] observe(input obs_e s);
        case (s)
            O_PLLRST:    return {3'b000, pll_reset};
            O_SYSRST:    return {3'b000, sys_rst_n};
            O_READY:     return {3'b000, pll_ready};
            O_STATE:     return {2'b00, ctrl_state};
            O_RETRY:     return retry_cnt;
            O_LOST:      return {3'b000, lock_lost};
            O_NL_SYSRST: return {3'b000, nl_sys_rst_n};
            default:     return 4'bxxxx;
        endcase
    endfunction

    task automatic push(input int e, input obs_e s, input logic [3:0] v);
        exp_t x;
        x.edge_i = e;
        x.sig    = s;
        x.val    = v;
        sb.push_back(x);
    endtask

    // Hold reset, then release it just after a falling edge so the next rising edge is edge 0
    task automatic do_reset(input logic lock_val);
        extlock = lock_val;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t x;
        reset   = 1'b1;
        extlock = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push(0, O_PLLRST, 4'd1);
        push(0, O_SYSRST, 4'd0);
        push(0, O_READY, 4'd0);
        push(0, O_STATE, 4'd0);
        push(0, O_RETRY, 4'd0);
        push(0, O_LOST, 4'd0);
        push(0, O_NL_SYSRST, 4'd0);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            total++;
            if (observe(x.sig) !== x.val) begin
                bad++;
                $display("FAIL reset %s: got %0h want %0h", x.sig.name(), observe(x.sig), x.val);
            end
        end
    endtask

    task automatic test_bringup();
        exp_t x;
        do_reset(1'b1);
        push(2, O_PLLRST, 4'd1);  push(2, O_STATE, 4'd0);
        push(3, O_PLLRST, 4'd0);  push(3, O_STATE, 4'd1);
        push(4, O_STATE, 4'd2);
        push(11, O_STATE, 4'd2);  push(11, O_SYSRST, 4'd0); push(11, O_READY, 4'd0);
        push(12, O_STATE, 4'd3);  push(12, O_SYSRST, 4'd1); push(12, O_READY, 4'd1);
        push(12, O_RETRY, 4'd0);
        push(20, O_STATE, 4'd3);  push(20, O_SYSRST, 4'd1);
        for (int e = 0; e < 21; e++) begin
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_i == e) begin
                x = sb.pop_front();
                total++;
                if (observe(x.sig) !== x.val) begin
                    bad++;
                    $display("FAIL bringup %s edge %0d: got %0h want %0h", x.sig.name(), e, observe(x.sig), x.val);
                end
            end
        end
    endtask

    task automatic test_timeout_retry();
        exp_t x;
        do_reset(1'b0);
        push(18, O_PLLRST, 4'd0); push(18, O_STATE, 4'd1); push(18, O_RETRY, 4'd0);
        push(19, O_PLLRST, 4'd1); push(19, O_STATE, 4'd0); push(19, O_RETRY, 4'd1);
        push(39, O_RETRY, 4'd2);
        push(279, O_RETRY, 4'd14);
        push(299, O_RETRY, 4'd15);
        push(399, O_RETRY, 4'd15);
        push(420, O_RETRY, 4'd15); push(420, O_SYSRST, 4'd0);
        for (int e = 0; e < 421; e++) begin
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_i == e) begin
                x = sb.pop_front();
                total++;
                if (observe(x.sig) !== x.val) begin
                    bad++;
                    $display("FAIL retry %s edge %0d: got %0h want %0h", x.sig.name(), e, observe(x.sig), x.val);
                end
            end
        end
    endtask

    task automatic test_unstable_lock();
        exp_t x;
        do_reset(1'b1);
        push(8, O_STATE, 4'd2);
        push(9, O_STATE, 4'd1);
        push(10, O_STATE, 4'd2);
        push(17, O_STATE, 4'd2); push(17, O_SYSRST, 4'd0);
        push(18, O_STATE, 4'd3); push(18, O_SYSRST, 4'd1); push(18, O_RETRY, 4'd0);
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_i == e) begin
                x = sb.pop_front();
                total++;
                if (observe(x.sig) !== x.val) begin
                    bad++;
                    $display("FAIL unstable %s edge %0d: got %0h want %0h", x.sig.name(), e, observe(x.sig), x.val);
                end
            end
            // One-cycle lock dropout while in STABLE
            if (e == 6) extlock = 1'b0;
            if (e == 7) extlock = 1'b1;
        end
    endtask

    task automatic test_lock_loss();
        exp_t x;
        do_reset(1'b1);
        push(16, O_SYSRST, 4'd1); push(16, O_PLLRST, 4'd0); push(16, O_LOST, 4'd0);
        push(17, O_SYSRST, 4'd0); push(17, O_PLLRST, 4'd1); push(17, O_LOST, 4'd1);
        push(17, O_STATE, 4'd0);  push(17, O_READY, 4'd0);
        push(21, O_STATE, 4'd1);
        push(22, O_STATE, 4'd1);
        push(23, O_STATE, 4'd2);
        push(30, O_SYSRST, 4'd0);
        push(31, O_SYSRST, 4'd1); push(31, O_LOST, 4'd1);
        push(40, O_LOST, 4'd1);
        for (int e = 0; e < 41; e++) begin
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_i == e) begin
                x = sb.pop_front();
                total++;
                if (observe(x.sig) !== x.val) begin
                    bad++;
                    $display("FAIL lockloss %s edge %0d: got %0h want %0h", x.sig.name(), e, observe(x.sig), x.val);
                end
            end
            if (e == 14) extlock = 1'b0;
            if (e == 20) extlock = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        exp_t x;
        int   k;
        // One timeout, then lock, run, lose lock, relock to get both sticky counters set
        do_reset(1'b0);
        for (int e = 0; e < 25; e++) @(negedge clk);
        extlock = 1'b1;
        k = 0;
        while (!pll_ready && k < 60) begin @(negedge clk); k++; end
        total++;
        if (!pll_ready) begin bad++; $display("FAIL async_first_run ready: got 0 want 1 within 60 cycles"); end
        extlock = 1'b0;
        for (int e = 0; e < 6; e++) @(negedge clk);
        extlock = 1'b1;
        k = 0;
        while (!pll_ready && k < 60) begin @(negedge clk); k++; end
        total++;
        if (!pll_ready) begin bad++; $display("FAIL async_second_run ready: got 0 want 1 within 60 cycles"); end
        push(0, O_LOST, 4'd1); push(0, O_RETRY, 4'd1); push(0, O_SYSRST, 4'd1);
        push(1, O_PLLRST, 4'd1); push(1, O_SYSRST, 4'd0); push(1, O_READY, 4'd0);
        push(1, O_STATE, 4'd0);  push(1, O_LOST, 4'd0);   push(1, O_RETRY, 4'd0);
        for (int ph = 0; ph < 2; ph++) begin
            // Phase 1: reset raised between edges, sampled before any rising edge
            if (ph == 1) begin
                #2 reset = 1'b1;
                #1;
            end
            while (sb.size() > 0 && sb[0].edge_i == ph) begin
                x = sb.pop_front();
                total++;
                if (observe(x.sig) !== x.val) begin
                    bad++;
                    $display("FAIL async %s phase %0d: got %0h want %0h", x.sig.name(), ph, observe(x.sig), x.val);
                end
            end
        end
    endtask

    task automatic test_nolock();
        exp_t x;
        do_reset(1'b0);
        push(11, O_NL_SYSRST, 4'd0);
        push(12, O_NL_SYSRST, 4'd1);
        push(60, O_NL_SYSRST, 4'd1);
        push(100, O_NL_SYSRST, 4'd1);
        for (int e = 0; e < 101; e++) begin
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_i == e) begin
                x = sb.pop_front();
                total++;
                if (observe(x.sig) !== x.val) begin
                    bad++;
                    $display("FAIL nolock %s edge %0d: got %0h want %0h", x.sig.name(), e, observe(x.sig), x.val);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout_retry();
        test_unstable_lock();
        test_lock_loss();
        test_async_reset();
        test_nolock();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
